// File: rtl/mux_scan_pkg.sv
// +------------------------------------------------------------------+
// | mux_scan_pkg: shared types and helpers for the mux select scanner |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package mux_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

  // Descending sweep so the last hit (lowest index) wins.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) r = i[SEL_W-1:0];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_next_ch.sv
// +------------------------------------------------------------------+
// | mux_scan_next_ch: next enabled channel strictly after cur, with  |
// | wrap-around; wrapped flags nxt <= cur. Revision: 1.0             |
// +------------------------------------------------------------------+
`default_nettype none

module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrapped
);

  logic [SEL_W-1:0] w_idx;

  // Offsets 8..1 in descending order: the nearest enabled channel wins,
  // and offset 8 (== cur itself) covers the single-channel case.
  always_comb begin
    nxt   = cur;
    w_idx = cur;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = cur + k[SEL_W-1:0];
      if (mask[w_idx]) nxt = w_idx;
    end
    wrapped = (nxt <= cur);
  end

endmodule

`default_nettype wire

// File: rtl/mux_sel_scanner.sv
// +------------------------------------------------------------------+
// | mux_sel_scanner: paced round-robin sampler for an 8:1 bit mux.   |
// | Optional sweep parity: MUX_SCAN_PARITY_EN. Revision: 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module mux_sel_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 8
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  input  logic               mux_out,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic [SEL_W-1:0]   smp_ch,
  output logic               smp_bit,
  output logic               busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic               sweep_done,
  output logic               sweep_par
`endif
);

  scan_state_t        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic               bit_q, bit_d;
  logic               stop_pend_q, stop_pend_d;

  logic [DWELL_W-1:0] w_dwell_ld;
  logic [SEL_W-1:0]   w_nxt;
  logic               w_wrapped;
  logic               w_accept;
  logic               w_to_idle;

  mux_scan_next_ch u_next_ch (
    .mask    (ch_mask),
    .cur     (sel_q),
    .nxt     (w_nxt),
    .wrapped (w_wrapped)
  );

  assign w_dwell_ld = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_accept   = (state_q == HOLD) && smp_ready;
  // A stop arriving on the accept cycle itself also ends the scan.
  assign w_to_idle  = stop_pend_q || stop || (ch_mask == '0);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    ch_d        = ch_q;
    bit_d       = bit_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && (ch_mask != '0)) begin
          sel_d   = lowest_set(ch_mask);
          cnt_d   = w_dwell_ld;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (stop) stop_pend_d = 1'b1;
        cnt_d = cnt_q - DWELL_W'(1);
        if (cnt_q <= DWELL_W'(1)) begin
          bit_d   = mux_out;
          ch_d    = sel_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stop) stop_pend_d = 1'b1;
        if (smp_ready) begin
          valid_d = 1'b0;
          if (w_to_idle) begin
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end else begin
            sel_d   = w_nxt;
            cnt_d   = w_dwell_ld;
            state_d = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      ch_q        <= '0;
      bit_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      ch_q        <= ch_d;
      bit_q       <= bit_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign sel       = sel_q;
  assign smp_valid = valid_q;
  assign smp_ch    = ch_q;
  assign smp_bit   = bit_q;
  assign busy      = (state_q != IDLE);

`ifdef MUX_SCAN_PARITY_EN
  logic done_q;
  logic par_q;

  // par_q runs across the sweep and is held for the pulse cycle, then
  // cleared; no accept can land in that cycle since SETTLE lasts >= 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (w_accept) begin
      par_q  <= par_q ^ bit_q;
      done_q <= w_to_idle || w_wrapped;
    end else if (done_q) begin
      done_q <= 1'b0;
      par_q  <= 1'b0;
    end
  end

  assign sweep_done = done_q;
  assign sweep_par  = par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_scanner.sv
// +------------------------------------------------------------------+
// | tb_mux_sel_scanner: directed self-checking bench for the scanner |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst, start, stop, smp_ready;
  logic [7:0] ch_mask, dwell;
  logic [2:0] sel, smp_ch;
  logic       mux_out, smp_valid, smp_bit, busy;
  logic [7:0] d_vec;
`ifdef MUX_SCAN_PARITY_EN
  logic       sweep_done, sweep_par;
`endif

  always #5 clk = ~clk;

  // Behavioural 8:1 mux being scanned
  assign mux_out = d_vec[sel];

  mux_sel_scanner #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .sel       (sel),
    .mux_out   (mux_out),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .smp_ch    (smp_ch),
    .smp_bit   (smp_bit),
    .busy      (busy)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .sweep_done(sweep_done),
    .sweep_par (sweep_par)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cnt = 0;

  logic [3:0] exp_q[$];
  logic [3:0] log_q[$];
  int         acc_t[$];
  int         done_par_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference scan order: first enabled channel, then nearest enabled
  // channel after the current one going upward modulo 8.
  function automatic int m_first(input logic [7:0] m);
    for (int k = 0; k < 8; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic int m_next(input logic [7:0] m, input int c);
    for (int k = 1; k <= 8; k++) if (m[(c + k) % 8]) return (c + k) % 8;
    return c;
  endfunction

  task automatic gen(input logic [7:0] m, input int n);
    int c;
    logic [2:0] c3;
    c = m_first(m);
    for (int i = 0; i < n; i++) begin
      c3 = c[2:0];
      exp_q.push_back({c3, d_vec[c]});
      c = m_next(m, c);
    end
  endtask

  // Monitor: scoreboard on accepts, stability while stalled
  logic       hold_prev = 1'b0;
  logic [2:0] p_ch, p_sel, last_ch;
  logic       p_bit;
  logic [3:0] mon_e;
  logic       p_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
      p_done    = 1'b0;
    end else begin
      if (hold_prev && smp_valid) begin
        chk("hold_ch", smp_ch, p_ch);
        chk("hold_bit", smp_bit, p_bit);
        chk("hold_sel", sel, p_sel);
      end
      if (smp_valid && smp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_sample", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("smp_ch", smp_ch, mon_e[3:1]);
          chk("smp_bit", smp_bit, mon_e[0]);
        end
        log_q.push_back({smp_ch, smp_bit});
        acc_t.push_back(cyc);
        acc_cnt++;
        last_ch = smp_ch;
      end
`ifdef MUX_SCAN_PARITY_EN
      if (p_done) chk("par_clear", sweep_par, 0);
      if (sweep_done) begin
        chk("done_ch", last_ch, 3);
        done_par_q.push_back(int'(sweep_par));
      end
      p_done = sweep_done;
`endif
      hold_prev = smp_valid && !smp_ready;
      p_ch  = smp_ch;
      p_bit = smp_bit;
      p_sel = sel;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target);
    int t = 0;
    while (acc_cnt < target && t < 2000) begin tick(); t++; end
    if (acc_cnt < target) chk("timeout_acc", acc_cnt, target);
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy && t < 2000) begin tick(); t++; end
    if (busy) chk("timeout_idle", 1, 0);
  endtask

  task automatic wait_valid;
    int t = 0;
    while (!smp_valid && t < 2000) begin tick(); t++; end
    if (!smp_valid) chk("timeout_valid", 0, 1);
  endtask

  // Scan n samples: stop is raised while the n-th sample is settling.
  task automatic run_scan(input logic [7:0] m, input logic [7:0] dw, input int n);
    int base;
    gen(m, n);
    ch_mask = m; dwell = dw;
    log_q.delete(); acc_t.delete();
    base = acc_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_acc(base + n - 1);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle();
    chk("scan_count", acc_cnt - base, n);
    chk("queue_left", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int exp_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int exp_t2[4]   = '{0, 7, 0, 7};
  int base;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; smp_ready = 1'b1;
    ch_mask = '0; dwell = '0; d_vec = '0;
    repeat (3) tick();
    chk("rst_sel", sel, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_ch", smp_ch, 0);
    chk("rst_bit", smp_bit, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 1: all channels, dwell 2, full wrap
    d_vec = 8'b1010_0101;
    run_scan(8'hFF, 8'd2, 10);
    chk("t1_log_size", log_q.size(), 10);
    for (int i = 0; i < 8; i++) begin
      chk("t1_ch", log_q[i][3:1], i);
      chk("t1_bit", log_q[i][0], exp_bits[i]);
    end
    chk("t1_wrap_ch", log_q[8][3:1], 0);
    for (int i = 1; i < 10; i++) chk("t1_spacing", acc_t[i] - acc_t[i-1], 3);

    // 2: mask 81, dwell 0 behaves as 1
    d_vec = 8'h80;
    run_scan(8'h81, 8'd0, 5);
    for (int i = 0; i < 4; i++) chk("t2_ch", log_q[i][3:1], exp_t2[i]);
    chk("t2_bit7", log_q[1][0], 1);
    for (int i = 1; i < 5; i++) chk("t2_spacing", acc_t[i] - acc_t[i-1], 2);

    // 3: back-pressure in HOLD
    d_vec = 8'h04;
    gen(8'h24, 2);
    ch_mask = 8'h24; dwell = 8'd3; smp_ready = 1'b0;
    base = acc_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_valid", smp_valid, 1);
      chk("t3_ch", smp_ch, 2);
      chk("t3_bit", smp_bit, 1);
      chk("t3_sel", sel, 2);
    end
    smp_ready = 1'b1; tick(); smp_ready = 1'b0;
    chk("t3_one_accept", acc_cnt - base, 1);
    chk("t3_valid_drop", smp_valid, 0);
    chk("t3_sel_adv", sel, 5);
    stop = 1'b1; tick(); stop = 1'b0;
    smp_ready = 1'b1;
    wait_idle();
    chk("t3_count", acc_cnt - base, 2);
    chk("t3_queue_left", exp_q.size(), 0);

    // 4: stop mid-SETTLE on ch3, then start with empty mask
    d_vec = 8'h08;
    gen(8'h08, 1);
    ch_mask = 8'h08; dwell = 8'd5;
    base = acc_cnt;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle();
    chk("t4_count", acc_cnt - base, 1);
    chk("t4_sel_hold", sel, 3);
    chk("t4_busy", busy, 0);
    ch_mask = 8'h00;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t4_mask0_idle", busy, 0);
    // start together with stop in IDLE: start wins, no stop is remembered
    gen(8'h08, 3);
    ch_mask = 8'h08;
    base = acc_cnt;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("t4_start_wins", busy, 1);
    wait_acc(base + 2);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle();
    chk("t4_count2", acc_cnt - base, 3);
    chk("t4_queue_left", exp_q.size(), 0);

    // 5: reset while holding a sample
    d_vec = 8'h10;
    ch_mask = 8'h10; dwell = 8'd2; smp_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    rst = 1'b1; tick();
    chk("t5_sel", sel, 0);
    chk("t5_valid", smp_valid, 0);
    chk("t5_ch", smp_ch, 0);
    chk("t5_bit", smp_bit, 0);
    chk("t5_busy", busy, 0);
    rst = 1'b0;
    smp_ready = 1'b1;
    base = acc_cnt;
    repeat (10) tick();
    chk("t5_no_leak", acc_cnt - base, 0);
    chk("t5_idle", busy, 0);

`ifdef MUX_SCAN_PARITY_EN
    // 6: two sweeps over ch0..3 with bits 1,1,1,0
    d_vec = 8'h07;
    done_par_q.delete();
    run_scan(8'h0F, 8'd1, 8);
    chk("t6_done_cnt", done_par_q.size(), 2);
    if (done_par_q.size() == 2) begin
      chk("t6_par0", done_par_q[0], 1);
      chk("t6_par1", done_par_q[1], 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
